// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Multi-cycle shift-add multiplier returning the full 2*WIDTH-bit product.
//   It handles unsigned operands and two's-complement signed operands.
//   A start/busy/done handshake lets the control unit stall while a multiply runs.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset; aborts any operation in flight
//   start        request a multiply; sampled only when not busy (IDLE or DONE)
//   signed_mode  1 = a/b are two's complement, 0 = unsigned; sampled with start
//   a, b         multiplicand / multiplier; sampled with start
//   busy         high during the WIDTH iteration cycles
//   done         one-cycle pulse; product_hi/product_lo valid in that cycle
//   product_lo   low WIDTH bits of the product (equals the truncated product)
//   product_hi   high WIDTH bits of the product
//
// Timing: start sampled at the end of cycle 0, busy in cycles 1..WIDTH,
// done and the product in cycle WIDTH+1. A start seen in the DONE cycle
// launches the next operation immediately.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [2*WIDTH-1:0] mcand_reg;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   mplier_reg;  // multiplier, shifted right each iteration
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               neg_reg;     // result sign when operating on magnitudes

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               start_neg;
  logic [2*WIDTH-1:0] add_term;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] prod_final;
  logic               last_iter;

  // Magnitudes are held as WIDTH-bit unsigned values. This keeps the
  // most-negative operand exact: negating 0x80 gives 0x80, which reads as 128.
  always_comb begin
    a_mag     = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
    b_mag     = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;
    start_neg = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // The final iteration's sum is folded straight into the product register.
  // The result is then ready in the DONE cycle without an extra stage.
  always_comb begin
    add_term   = mplier_reg[0] ? mcand_reg : '0;
    acc_sum    = acc_reg + add_term;
    prod_final = neg_reg ? (~acc_sum + ONE_2W) : acc_sum;
    last_iter  = (cnt_reg == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_lo <= '0;
      product_hi <= '0;
    end else begin
      done <= 1'b0;
      if (state_reg == RUN) begin
        // start is deliberately ignored here; latched operands stay intact.
        acc_reg    <= acc_sum;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CW'(1);
        if (last_iter) begin
          state_reg  <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          product_lo <= prod_final[WIDTH-1:0];
          product_hi <= prod_final[2*WIDTH-1:WIDTH];
        end
      end else if (start) begin
        // IDLE or DONE: accept a new operation (back-to-back from DONE).
        state_reg  <= RUN;
        mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
        mplier_reg <= b_mag;
        acc_reg    <= '0;
        cnt_reg    <= '0;
        neg_reg    <= start_neg;
        busy       <= 1'b1;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier for the LEG datapath. It replaces the purely combinational 8-bit low-product multiplier with a multi-cycle unit that returns the full double-width product. It supports unsigned and signed (two's complement) operands and uses a start/busy/done handshake, so the control unit can stall on MUL.

Parameters:
WIDTH, 8, operand width in bits (legal 2..64); product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a multiply; sampled only when not busy
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; product valid this cycle
product_lo  output  WIDTH  low half of product
product_hi  output  WIDTH  high half of product

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). The polarity and synchronicity are fixed.
- Reset values: busy=0, done=0, product_lo=0, product_hi=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: waiting for start.
  - RUN: WIDTH iterations.
  - DONE: one cycle, presents the result.
- IDLE -> RUN when start=1:
  - Latch a, b and signed_mode.
  - In signed mode, latch |a|, |b| and neg = a[MSB] XOR b[MSB].
  - Clear the 2*WIDTH accumulator and the counter.
- RUN, each cycle:
  - If the current multiplier LSB is 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplier right and the multiplicand left.
  - Increment the counter.
  - After WIDTH iterations -> DONE.
- DONE:
  - done=1 for exactly one cycle.
  - {product_hi, product_lo} = accumulator, two's-complement negated if neg.
  - Next state is IDLE. If start=1 in the DONE cycle, go directly to RUN with the new operands (back-to-back).
- Latency: start high in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 and product valid in cycle WIDTH+1. Total WIDTH+1 cycles; the next op can begin in cycle WIDTH+1.
- product_lo/product_hi hold their last result until the next DONE. They are not cleared by a new start.
- start while busy (RUN) is ignored; latched operands are unaffected.
- busy is 0 in IDLE and DONE.
- The full product is always exact; there is no overflow flag.
  - product_lo alone equals the WIDTH-bit truncated product, which matches the legacy MUL result.
- Signed edge case: most-negative x most-negative (e.g. -128 x -128 at WIDTH=8) = +2^(2*WIDTH-2), exact. The magnitude path must carry WIDTH bits unsigned, so |-128| = 128 is representable.
- Zero operands take the full WIDTH iterations; there is no early termination.
- rst asserted mid-RUN aborts the operation:
  - Next cycle: IDLE, busy=0, done=0, products=0.
  - No done pulse is produced for the aborted op.
- rst has priority over start in the same cycle.

Test Plan:
- WIDTH=8, unsigned, a=13, b=11, start 1 cycle -> busy cycles 1..8; done in cycle 9 only; product_hi=0x00, product_lo=0x8F (143).
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> product_hi=0xFE, product_lo=0x01. Then signed_mode=1, same operands (-1 x -1) -> product_hi=0x00, product_lo=0x01.
- WIDTH=8, signed, a=0xFD (-3), b=0x05 -> 0xFFF1 (hi=0xFF, lo=0xF1). Then a=0x80, b=0x80 -> hi=0x40, lo=0x00.
- WIDTH=8: start 7x9, pulse start with 2x2 in cycle 4 -> ignored; done cycle 9 with lo=0x3F. Start 2x2 held in cycle 9 (DONE) -> accepted; done cycle 18 with lo=0x04.
- WIDTH=8: start 100x100, assert rst in cycle 5 -> cycle 6 busy=0, products=0; no done pulse in cycles 6..12.
- WIDTH=4 instance, unsigned, a=15, b=15 -> done in cycle 5, product_hi=0xE, product_lo=0x1. Also WIDTH=16, a=0x1234, b=0x0100 -> hi=0x0012, lo=0x3400, done in cycle 17.
